// File: rtl/ntt_sched_pkg.sv
// Shared state encoding and default widths for the NTT buffer scheduler.
// No logic; types and constants only.
package ntt_sched_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BUF_LEN    = 4;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_WDOG_CYC   = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_LOAD     = 3'd2,
    S_GAP      = 3'd3,
    S_DRAIN    = 3'd4,
    S_WAIT_RDY = 3'd5
  } state_t;

endpackage

// File: rtl/ntt_buffer_scheduler_rr_pick.sv
// Round-robin pick: first set req at or after ptr, wrapping; one-hot plus index.
// Combinational, zero latency; no flow control.
// Backpressure: none, the caller decides when to take the pick.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick_oh,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       pick_any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!pick_any && req[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
    pick_oh = pick_any ? (NUM_REQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/ntt_buffer_scheduler.sv
// Shares one NTT frame buffer among NUM_REQ requesters, round-robin, one frame at a time.
// Latency: buf_start at t, LOAD t+1..t+BUF_LEN, DRAIN t+BUF_LEN+2..t+2*BUF_LEN+1, done after buf_ready.
// Backpressure: stalls in IDLE/WAIT_RDY on buf_ready; ARB_WATCHDOG_EN bounds the WAIT_RDY stall.
module ntt_buffer_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_LEN    = DEF_BUF_LEN,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int WDOG_CYC   = DEF_WDOG_CYC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            data_pop,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [NUM_REQ-1:0]            out_valid,
  output logic [NUM_REQ-1:0]            done_pulse,
  output logic                          busy,
  output logic                          buf_start,
  output logic [DATA_WIDTH-1:0]         buf_in,
  input  logic                          buf_ready,
  input  logic [DATA_WIDTH-1:0]         buf_out,
  output logic                          wdog_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUF_LEN + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               wd_expire;
  logic [IDX_W-1:0]   ptr_after;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  assign ptr_after = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign gnt       = gnt_q;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    gnt_nxt    = gnt_q;
    gidx_nxt   = gidx;
    ptr_nxt    = ptr;
    buf_start  = 1'b0;
    buf_in     = '0;
    data_pop   = '0;
    out_data   = '0;
    out_valid  = '0;
    done_pulse = '0;
    case (state)
      S_IDLE: begin
        if (buf_ready && pick_any) begin
          gnt_nxt   = pick_oh;
          gidx_nxt  = pick_idx;
          cnt_nxt   = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        buf_start = 1'b1;
        cnt_nxt   = CNT_W'(BUF_LEN - 1);
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        buf_in   = req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
        data_pop = gnt_q;
        if (cnt == '0) begin
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_GAP: begin
        cnt_nxt   = CNT_W'(BUF_LEN - 1);
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_data  = buf_out;
        out_valid = gnt_q;
        if (cnt == '0) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT_RDY;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WAIT_RDY: begin
        if (buf_ready) begin
          done_pulse = gnt_q;
          ptr_nxt    = ptr_after;
          gnt_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = S_IDLE;
        end else if (wd_expire) begin
          // Timed-out frame is abandoned silently but still counts as a turn.
          ptr_nxt   = ptr_after;
          gnt_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      gnt_q <= '0;
      gidx  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gnt_q <= gnt_nxt;
      gidx  <= gidx_nxt;
      ptr   <= ptr_nxt;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_err_q;

  assign wd_expire = (state == S_WAIT_RDY) && !buf_ready && (wd_cnt == WD_W'(WDOG_CYC - 1));
  assign wdog_err  = wd_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT_RDY) ? wd_cnt + 1'b1 : '0;
      if (wd_expire) begin
        wd_err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_buffer_scheduler.sv
// Scoreboard bench for ntt_buffer_scheduler with a behavioural frame buffer model.
module tb_ntt_buffer_scheduler;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] gnt, data_pop, out_valid, done_pulse;
  logic [DW-1:0] out_data, buf_in, buf_out;
  logic          busy, buf_start, buf_ready, wdog_err;
  logic          stub_mode;

  ntt_buffer_scheduler #(
    .DATA_WIDTH (DW),
    .BUF_LEN    (BL),
    .NUM_REQ    (NR),
    .WDOG_CYC   (16)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .data_pop   (data_pop),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .done_pulse (done_pulse),
    .busy       (busy),
    .buf_start  (buf_start),
    .buf_in     (buf_in),
    .buf_ready  (buf_ready),
    .buf_out    (buf_out),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requesters: word k of any frame from requester i is (i+1)*16 + k + 1.
  int pop_cnt [NR];
  for (genvar i = 0; i < NR; i++) begin : g_req
    assign req_data[i*DW +: DW] = DW'((i + 1) * 16 + (pop_cnt[i] % BL) + 1);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) pop_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NR; i++) if (data_pop[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    end
  end

  // Buffer model: captures BL words after start, replays them one cycle later, then raises ready.
  logic [DW-1:0] mem [BL];
  int mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt      <= 0;
      buf_ready <= 1'b1;
      buf_out   <= '0;
    end else if (buf_start) begin
      mcnt      <= 1;
      buf_ready <= 1'b0;
    end else if (mcnt >= 1 && mcnt <= BL) begin
      mem[mcnt-1] <= buf_in;
      mcnt        <= mcnt + 1;
    end else if (mcnt > BL && mcnt <= 2 * BL) begin
      buf_out <= mem[mcnt-BL-1];
      mcnt    <= mcnt + 1;
    end else if (mcnt == 2 * BL + 1) begin
      buf_out <= '0;
      mcnt    <= 0;
      if (!stub_mode) buf_ready <= 1'b1;
    end
  end

  typedef struct {
    int            idx;
    logic [DW-1:0] dat;
  } out_t;

  int   exp_gnt  [$];
  out_t exp_out  [$];
  int   exp_done [$];

  task automatic push_frame(input int idx, input bit with_done);
    out_t o;
    exp_gnt.push_back(idx);
    for (int k = 0; k < BL; k++) begin
      o.idx = idx;
      o.dat = DW'((idx + 1) * 16 + k + 1);
      exp_out.push_back(o);
    end
    if (with_done) exp_done.push_back(idx);
  endtask

  // Monitor: pops expectations whenever the DUT presents a start, output beat or done.
  int start_cyc = 0;
  int beat      = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (buf_start) begin
        if (exp_gnt.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_start: gnt=%b with no grant expected", gnt);
        end else begin
          int e;
          e = exp_gnt.pop_front();
          check("gnt", 64'(gnt), 64'(1 << e));
        end
        start_cyc = cyc;
        beat      = 0;
      end
      if (|out_valid) begin
        if (exp_out.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_out: out_valid=%b data=0x%0h", out_valid, out_data);
        end else begin
          out_t o;
          o = exp_out.pop_front();
          check("out_valid", 64'(out_valid), 64'(1 << o.idx));
          check("out_data", 64'(out_data), 64'(o.dat));
          check("out_latency", 64'(cyc - start_cyc), 64'(BL + 2 + beat));
        end
        beat++;
      end
      if (|done_pulse) begin
        if (exp_done.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: done_pulse=%b", done_pulse);
        end else begin
          int e;
          e = exp_done.pop_front();
          check("done_pulse", 64'(done_pulse), 64'(1 << e));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},        64'(gnt), 64'h0);
    check({tag, "_data_pop"},   64'(data_pop), 64'h0);
    check({tag, "_out_valid"},  64'(out_valid), 64'h0);
    check({tag, "_done"},       64'(done_pulse), 64'h0);
    check({tag, "_busy"},       64'(busy), 64'h0);
    check({tag, "_buf_start"},  64'(buf_start), 64'h0);
    check({tag, "_buf_in"},     64'(buf_in), 64'h0);
    check({tag, "_out_data"},   64'(out_data), 64'h0);
    check({tag, "_wdog_err"},   64'(wdog_err), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve(input logic [NR-1:0] mask, input int frames);
    int seen;
    int budget;
    seen   = 0;
    budget = 0;
    req    = mask;
    while (seen < frames && budget < 40 * frames) begin
      @(negedge clk);
      budget++;
      if (|done_pulse) begin
        seen++;
        if (seen == frames) req = '0;
      end
    end
    req = '0;
    check("serve_frames", 64'(seen), 64'(frames));
    @(negedge clk);
  endtask

  initial begin
    int pops;
    int budget;
    int outs;
    bit done_seen;
    rst       = 1'b1;
    req       = '0;
    stub_mode = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Single requester 1.
    push_frame(1, 1);
    serve(4'b0010, 1);

    // All requesting: strict rotation from ptr 0.
    do_reset();
    push_frame(0, 1); push_frame(1, 1); push_frame(2, 1); push_frame(3, 1); push_frame(0, 1);
    serve(4'b1111, 5);

    // Two requesters alternate.
    do_reset();
    push_frame(0, 1); push_frame(2, 1); push_frame(0, 1);
    serve(4'b0101, 3);

    // Reset during LOAD cycle 2; ptr (1 here) must be back to 0 afterwards.
    exp_gnt.push_back(2);
    req    = 4'b0100;
    pops   = 0;
    budget = 0;
    while (pops < 2 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (data_pop[2]) pops++;
    end
    check("t4_reach_load2", 64'(pops), 64'd2);
    rst = 1'b1;
    req = '0;
    #1;
    check_outputs_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    push_frame(0, 1); push_frame(3, 1);
    serve(4'b1001, 2);

    // Requester 2 drops req during LOAD; frame still completes.
    push_frame(2, 1);
    req       = 4'b0100;
    pops      = 0;
    budget    = 0;
    done_seen = 1'b0;
    while (!done_seen && budget < 60) begin
      @(negedge clk);
      budget++;
      if (data_pop[2]) begin
        pops++;
        req[2] = 1'b0;
      end
      if (done_pulse[2]) done_seen = 1'b1;
    end
    check("t6_done_seen", 64'(done_seen), 64'd1);
    check("t6_pops", 64'(pops), 64'd4);
    @(negedge clk);
    check("t6_idle", 64'(busy), 64'd0);

    // Buffer never returns ready after DRAIN.
    stub_mode = 1'b1;
    push_frame(0, 0);
    req    = 4'b0001;
    outs   = 0;
    budget = 0;
    while (outs < BL && budget < 60) begin
      @(negedge clk);
      budget++;
      if (buf_start) req = '0;
      if (out_valid[0]) outs++;
    end
    check("t5_outs", 64'(outs), 64'(BL));
    repeat (20) @(negedge clk);
`ifdef ARB_WATCHDOG_EN
    check("t5_wdog_err", 64'(wdog_err), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
`else
    check("t5_wdog_err", 64'(wdog_err), 64'd0);
    check("t5_busy", 64'(busy), 64'd1);
`endif
    stub_mode = 1'b0;
    do_reset();
    check("t5_after_reset_wdog", 64'(wdog_err), 64'd0);

    repeat (2) @(negedge clk);
    check("left_gnt", 64'(exp_gnt.size()), 64'd0);
    check("left_out", 64'(exp_out.size()), 64'd0);
    check("left_done", 64'(exp_done.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
